// File: rtl/sub_bytes_engine.sv
// AES byte-substitution engine: forward (SubBytes) or inverse (InvSubBytes)
// S-box applied to a 128-bit state, LANES bytes per falling clock edge.
// Byte 0 is the most significant byte of the [0:127] state vectors.

// One S-box lane: both substitution tables for a single byte, muxed by mode.
// The tables are generated by logic (GF(2^8) inversion plus affine map)
// rather than typed in, so they cannot hold a transcription error.
module sub_bytes_lane (
   input  logic [7:0] i_byte,
   input  logic       i_inverse,
   output logic [7:0] o_byte
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gmul(x, x);
      x3   = gmul(x2, x);
      x6   = gmul(x3, x3);
      x12  = gmul(x6, x6);
      x15  = gmul(x12, x3);
      x30  = gmul(x15, x15);
      x60  = gmul(x30, x30);
      x120 = gmul(x60, x60);
      x240 = gmul(x120, x120);
      x252 = gmul(x240, x12);
      return gmul(x252, x2);
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   logic [7:0] fwd_byte;
   logic [7:0] inv_byte;

   // forward = affine(inverse(x)); inverse = inverse(inverse_affine(x))
   always_comb begin
      fwd_byte = ginv(i_byte);
      fwd_byte = fwd_byte ^ rotl(fwd_byte, 1) ^ rotl(fwd_byte, 2) ^
                 rotl(fwd_byte, 3) ^ rotl(fwd_byte, 4) ^ 8'h63;
      inv_byte = ginv(rotl(i_byte, 1) ^ rotl(i_byte, 3) ^ rotl(i_byte, 6) ^ 8'h05);
      o_byte   = i_inverse ? inv_byte : fwd_byte;
   end

endmodule

module sub_bytes_engine #(
   parameter int LANES = 4
) (
   input  logic         i_clock,
   input  logic         i_reset_n,
   input  logic [0:127] i_data,
   input  logic         i_inverse,
   input  logic         i_valid,
   output logic         o_ready,
   output logic [0:127] o_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic         o_busy
);

   localparam int ITER = 16 / LANES;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic [0:15][7:0]     work_q, work_d;
   logic [0:127]         data_q, data_d;
   logic                 last_grp;
   logic [LANES-1:0][7:0] lane_in;
   logic [LANES-1:0][7:0] lane_out;

   // byte index handled by lane l during group c (groups run MSB first)
   function automatic logic [3:0] byte_idx(input logic [CW-1:0] c, input int l);
      return 4'(int'(c) * LANES + l);
   endfunction

   assign last_grp = (cnt_q == CW'(ITER - 1));

   // lane mux: route the current byte group from the working register
   always_comb begin
      lane_in = '0;
      for (int l = 0; l < LANES; l++) lane_in[l] = work_q[byte_idx(cnt_q, l)];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sub_bytes_lane u_lane (
         .i_byte    (lane_in[l]),
         .i_inverse (mode_q),
         .o_byte    (lane_out[l])
      );
   end

   // state register (falling edge, async reset)
   always_ff @(negedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   // next-state: accept in IDLE, walk ITER groups, hold result until taken
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_valid)  state_d = S_RUN;
         S_RUN:   if (last_grp) state_d = S_DONE;
         S_DONE:  if (i_ready)  state_d = S_IDLE;
         default:               state_d = S_IDLE;
      endcase
   end

   // FSM outputs are pure state decodes
   always_comb begin
      o_ready = (state_q == S_IDLE);
      o_busy  = (state_q != S_IDLE);
      o_valid = (state_q == S_DONE);
   end

   // datapath next-state: capture, substitute one group per edge, publish
   always_comb begin
      cnt_d  = cnt_q;
      mode_d = mode_q;
      work_d = work_q;
      data_d = data_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               work_d = i_data;
               mode_d = i_inverse;
               cnt_d  = '0;
            end
         end
         S_RUN: begin
            for (int l = 0; l < LANES; l++) work_d[byte_idx(cnt_q, l)] = lane_out[l];
            cnt_d = cnt_q + 1'b1;
            if (last_grp) begin
               cnt_d  = '0;
               data_d = work_d;
            end
         end
         default: ;
      endcase
   end

   // datapath registers; reset aborts any block in flight
   always_ff @(negedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q  <= '0;
         mode_q <= 1'b0;
         work_q <= '0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         work_q <= work_d;
         data_q <= data_d;
      end
   end

   assign o_data = data_q;

endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
- Parametrised successor to the single-mode inverse byte-substitution stage.
- Applies either the forward AES S-box (SubBytes) or the inverse S-box (InvSubBytes) to a 128-bit state; the mode is selected per block.
- Processes LANES bytes per cycle, trading latency against S-box instance count.
- Sits between the round-key/shift stages of the AES round datapath and uses a valid/ready handshake on both sides instead of an enable strobe.

Parameters:
- LANES, default 4: S-box lanes (bytes substituted per cycle). Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- ITER, derived as 16/LANES: number of RUN cycles per block. Not user-overridable.

Ports:
- i_clock  in  1  Clock. All state updates occur on the falling edge, matching the rest of the AES datapath.
- i_reset_n  in  1  Asynchronous active-low reset.
- i_data  in  128  Input state, [0:127]. Byte k is bits [8k:8k+7]; byte 0 is the MSB.
- i_inverse  in  1  Mode select: 0 = forward S-box, 1 = inverse S-box. Sampled with i_data.
- i_valid  in  1  Input block valid.
- o_ready  out  1  Engine can accept a block.
- o_data  out  128  Substituted state, [0:127].
- o_valid  out  1  o_data holds a complete result.
- i_ready  in  1  Downstream accepts the result.
- o_busy  out  1  High in RUN or DONE.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - state = IDLE; o_data = 0; o_valid = 0; o_ready = 1; o_busy = 0; group counter = 0.
  - Reset asserted mid-RUN or mid-DONE aborts the block immediately. No partial result is ever flagged valid.
- State machine, three states:
  - IDLE: o_ready=1. On an edge with i_valid=1:
    - capture i_data into the working register and i_inverse into the mode register;
    - counter = 0; go to RUN.
    - With i_valid=0, remain in IDLE.
  - RUN: o_ready=0. Each edge:
    - bytes [counter*LANES .. counter*LANES+LANES-1] of the working register are replaced by S-box(byte), using the forward or inverse table per the captured mode;
    - counter increments.
    - On the edge where counter == ITER-1, the last group is written, o_data takes the completed register, o_valid is set, and the FSM goes to DONE.
    - Byte groups are processed in ascending byte order (MSB group first).
  - DONE: o_valid=1, o_ready=0.
    - o_data is held stable while i_ready=0.
    - On an edge with i_ready=1: o_valid clears and the FSM returns to IDLE.
    - o_data keeps its last value in IDLE; it is not cleared.
- Latency and throughput:
  - o_valid is observable ITER falling edges after the accepting edge (LANES=16: 1 edge; LANES=4: 4; LANES=1: 16).
  - Throughput is one block per ITER+2 cycles minimum.
  - There is no overlap of input acceptance with output drain.
- Input stability: changes to i_data / i_inverse after acceptance have no effect. i_valid asserted outside IDLE is ignored; it is not queued.
- Tables:
  - Both 256-entry tables are combinational ROMs per lane, selected by the mode register.
  - Forward table per FIPS-197 Fig. 7; inverse per Fig. 14.
  - The lane mux feeds LANES table pairs from the working register using the counter.
- Width rules: the counter is $clog2(ITER) bits, minimum 1 bit. With LANES=16 the counter is unused and RUN lasts exactly one edge.
- Simultaneous events: i_ready=1 while in RUN has no effect, and i_valid in the same edge as a DONE->IDLE transition is not accepted. Acceptance requires o_ready=1 before the edge.

Test Plan:
- Forward: LANES=4, i_inverse=0, i_data=000102030405060708090a0b0c0d0e0f, i_valid pulse -> o_valid after 4 edges, o_data=637c777bf26b6fc53001672bfed7ab76, o_ready=0 throughout RUN.
- Inverse round-trip: feed 637c777bf26b6fc53001672bfed7ab76 with i_inverse=1 -> o_data=000102030405060708090a0b0c0d0e0f. Repeat for LANES=1 (16 edges) and LANES=16 (1 edge).
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_data and o_valid stable, o_ready=0, new i_valid with all-ff ignored. Release i_ready -> IDLE; next all-ff block gives o_data=16 repeated (forward).
- Mode latch: accept 53535353... with i_inverse=0, toggle i_inverse during RUN -> every byte = ed.
- Reset mid-RUN: assert i_reset_n=0 at edge 2 of 4 -> o_valid=0, o_data=0, o_ready=1 asynchronously. After release, a fresh 52525252... inverse block yields 48 repeated.
- Exhaustive: LANES=2, all 256 byte values in each lane position, both modes -> match reference tables, and inverse(forward(x))=x.
